// File: rtl/cpu_defs.sv
// Shared definitions for the fetch/decode front end: halt opcode, reset
// values, and the stage-control state encoding.
package cpu_defs;

  localparam logic [5:0]  OP_HALT   = 6'b111111;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    HALT  = 2'd2
  } state_e;

endpackage : cpu_defs

// File: rtl/if_id_stage_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead
// of wrapping so a long stall never reads back as a short one.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // Clear wins over enable; count stops once every bit is set.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule : sat_counter

// File: rtl/if_id_stage_ctrl.sv
// IF/ID stage controller: owns the PC and IF/ID register, applies hazard
// holds and redirects, and latches a sticky halt once the halt opcode
// reaches ID.
//
// state | meaning
// RUN   | normal fetch
// STALL | previous cycle was held by the hazard unit
// HALT  | terminal, left only by reset
module if_id_stage_ctrl
  import cpu_defs::*;
#(
  parameter int                PC_W      = 32,
  parameter logic [PC_W-1:0]   RESET_PC  = PC_W'(cpu_defs::RESET_PC),
  parameter logic [PC_W-1:0]   NOP_INSTR = PC_W'(cpu_defs::NOP_INSTR),
  parameter int                CNT_W     = 8
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              PCWrite_HD,
  input  logic              IF_ID_write,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  input  logic [PC_W-1:0]   imem_instr,
  output logic [PC_W-1:0]   pc,
  output logic [PC_W-1:0]   id_pc4,
  output logic [PC_W-1:0]   id_instr,
  output logic              id_valid,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cnt
);

  state_e          r_state;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_id_pc4;
  logic [PC_W-1:0] r_id_instr;
  logic            r_id_valid;
  logic            r_halted;

  state_e          w_state_nxt;
  logic [PC_W-1:0] w_pc_nxt;
  logic [PC_W-1:0] w_id_pc4_nxt;
  logic [PC_W-1:0] w_id_instr_nxt;
  logic            w_id_valid_nxt;
  logic            w_cnt_en;
  logic            w_halt_seen;
  logic [PC_W-1:0] w_pc_plus4;
  logic [PC_W-1:0] w_redirect_aligned;

  assign w_pc_plus4         = r_pc + PC_W'(4);
  assign w_redirect_aligned = redirect_pc & ~PC_W'(3);
  assign w_halt_seen        = r_id_valid && (r_id_instr[PC_W-1 -: 6] == OP_HALT);

  // Next-state and datapath selection; halt beats redirect beats hazard hold.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_id_pc4_nxt   = r_id_pc4;
    w_id_instr_nxt = r_id_instr;
    w_id_valid_nxt = r_id_valid;
    w_cnt_en       = 1'b0;

    unique case (r_state)
      RUN, STALL: begin
        if (w_halt_seen) begin
          w_state_nxt = HALT;
        end else if (redirect) begin
          // A flushed IF/ID has nothing worth holding, so the stall is dropped.
          w_pc_nxt       = w_redirect_aligned;
          w_id_instr_nxt = NOP_INSTR;
          w_id_valid_nxt = 1'b0;
          w_state_nxt    = RUN;
        end else begin
          if (!PCWrite_HD || !IF_ID_write) begin
            w_state_nxt = STALL;
            w_cnt_en    = 1'b1;
          end else begin
            w_state_nxt = RUN;
          end
          // PC and IF/ID holds are independent of each other.
          if (PCWrite_HD) begin
            w_pc_nxt = w_pc_plus4;
          end
          if (IF_ID_write) begin
            w_id_instr_nxt = imem_instr;
            w_id_pc4_nxt   = w_pc_plus4;
            w_id_valid_nxt = 1'b1;
          end
        end
      end
      HALT: begin
        w_state_nxt = HALT;
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  // State, PC and IF/ID registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      r_state    <= RUN;
      r_pc       <= RESET_PC;
      r_id_pc4   <= '0;
      r_id_instr <= NOP_INSTR;
      r_id_valid <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_id_pc4   <= w_id_pc4_nxt;
      r_id_instr <= w_id_instr_nxt;
      r_id_valid <= w_id_valid_nxt;
      r_halted   <= (w_state_nxt == HALT);
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .i_clk (CLK),
    .i_clr (!Reset),
    .i_en  (w_cnt_en),
    .o_cnt (stall_cnt)
  );

  assign pc       = r_pc;
  assign id_pc4   = r_id_pc4;
  assign id_instr = r_id_instr;
  assign id_valid = r_id_valid;
  assign halted   = r_halted;

endmodule : if_id_stage_ctrl

// File: tb/tb_if_id_stage_ctrl.sv
// Self-checking bench for if_id_stage_ctrl: directed scenarios plus a
// randomized phase, all compared against a rule-level reference model.
module tb_if_id_stage_ctrl;

  logic        CLK;
  logic        Reset;
  logic        PCWrite_HD;
  logic        IF_ID_write;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_instr;
  logic [31:0] pc;
  logic [31:0] id_pc4;
  logic [31:0] id_instr;
  logic        id_valid;
  logic        halted;
  logic [7:0]  stall_cnt;

  int n_pass  = 0;
  int n_total = 0;

  // reference model state
  logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
  logic        m_valid, m_halted;

  if_id_stage_ctrl #(
    .PC_W      (32),
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0000),
    .CNT_W     (8)
  ) dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .PCWrite_HD  (PCWrite_HD),
    .IF_ID_write (IF_ID_write),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_instr  (imem_instr),
    .pc          (pc),
    .id_pc4      (id_pc4),
    .id_instr    (id_instr),
    .id_valid    (id_valid),
    .halted      (halted),
    .stall_cnt   (stall_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] tagw(input logic [31:0] a);
    return {8'hA5, a[23:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock edge of the reference behaviour.
  task automatic model_edge(input logic rst_b, input logic pcw, input logic ifw,
                            input logic rd, input logic [31:0] rpc, input logic [31:0] ins);
    if (!rst_b) begin
      m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
      m_valid = 1'b0; m_halted = 1'b0; m_cnt = 32'h0;
    end else if (m_halted) begin
      // frozen
    end else if (m_valid && (m_instr[31:26] == 6'b111111)) begin
      m_halted = 1'b1;
    end else if (rd) begin
      m_pc    = rpc & 32'hFFFF_FFFC;
      m_instr = 32'h0;
      m_valid = 1'b0;
    end else begin
      if ((!pcw || !ifw) && (m_cnt < 32'd255)) m_cnt = m_cnt + 32'd1;
      if (ifw) begin
        m_instr = ins;
        m_pc4   = m_pc + 32'd4;
        m_valid = 1'b1;
      end
      if (pcw) m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic step(input string tag, input logic rst_b, input logic pcw, input logic ifw,
                      input logic rd, input logic [31:0] rpc, input logic [31:0] ins);
    @(negedge CLK);
    Reset = rst_b; PCWrite_HD = pcw; IF_ID_write = ifw;
    redirect = rd; redirect_pc = rpc; imem_instr = ins;
    model_edge(rst_b, pcw, ifw, rd, rpc, ins);
    @(posedge CLK);
    #1;
    chk({tag, ".pc"},       pc,              m_pc);
    chk({tag, ".id_instr"}, id_instr,        m_instr);
    chk({tag, ".id_pc4"},   id_pc4,          m_pc4);
    chk({tag, ".id_valid"}, 32'(id_valid),   32'(m_valid));
    chk({tag, ".halted"},   32'(halted),     32'(m_halted));
    chk({tag, ".stall_cnt"},32'(stall_cnt),  m_cnt);
  endtask

  task automatic run(input string tag);
    step(tag, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, tagw(m_pc));
  endtask

  logic [31:0] saved_pc;

  initial begin
    Reset = 1'b0; PCWrite_HD = 1'b1; IF_ID_write = 1'b1;
    redirect = 1'b0; redirect_pc = 32'h0; imem_instr = 32'h0;

    // reset
    step("rst0", 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
    step("rst1", 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", 32'(id_valid), 32'h0);

    // free run up to pc=0x10
    for (int i = 0; i < 4; i++) run("free");
    chk("free_pc", pc, 32'h10);
    chk("free_id", id_instr, tagw(32'hC));

    // two-cycle full stall at 0x10
    step("stall", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, tagw(m_pc));
    step("stall", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, tagw(m_pc));
    chk("stall_pc", pc, 32'h10);
    chk("stall_cnt2", 32'(stall_cnt), 32'd2);
    run("resume");
    chk("resume_pc", pc, 32'h14);

    // stall and redirect together: redirect wins, no count
    step("stall_rd", 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0043, tagw(m_pc));
    chk("rd_pc", pc, 32'h40);
    chk("rd_cnt", 32'(stall_cnt), 32'd2);

    // independent holds
    step("pc_hold", 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, tagw(m_pc));
    step("ifid_hold", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, tagw(m_pc));

    // randomized phase, halt opcode kept out of imem
    for (int i = 0; i < 300; i++) begin
      logic [31:0] ins;
      ins = $urandom;
      if (ins[31:26] == 6'b111111) ins[31] = 1'b0;
      step("rand", 1'b1, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 7) == 0), $urandom, ins);
    end

    // saturation
    for (int i = 0; i < 300; i++) step("sat", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, tagw(m_pc));
    chk("sat_cnt", 32'(stall_cnt), 32'd255);

    // halt
    step("hrst", 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
    run("hrun");
    run("hrun");
    step("hload", 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'hFC00_0000);
    saved_pc = m_pc;
    run("hseen");
    chk("halted_set", 32'(halted), 32'h1);
    step("hredir", 1'b1, 1'b1, 1'b1, 1'b1, 32'h80, tagw(m_pc));
    step("hstall", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, tagw(m_pc));
    chk("halt_pc", pc, saved_pc);
    step("hexit", 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
    chk("hexit_pc", pc, 32'h0);
    chk("hexit_halted", 32'(halted), 32'h0);

    // reset mid-stall with redirect
    for (int i = 0; i < 3; i++) run("mrun");
    step("mstall", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, tagw(m_pc));
    step("mrst", 1'b0, 1'b0, 1'b0, 1'b1, 32'h40, tagw(m_pc));
    chk("mrst_pc", pc, 32'h0);
    chk("mrst_cnt", 32'(stall_cnt), 32'h0);
    chk("mrst_instr", id_instr, 32'h0);
    run("post");
    chk("post_valid", 32'(id_valid), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_if_id_stage_ctrl
